// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM arbiter
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DONE  = 3'd2,
    WRITE = 3'd3,
    WHOLD = 3'd4
  } state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

  // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side bundle for the SRAM arbiter
interface sram_arbiter_if #(
  parameter int ADDR_W = sram_pkg::SRAM_ADDR_W,
  parameter int DATA_W = sram_pkg::SRAM_DATA_W
);

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_ack;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;

  // CPU fetch/mem stages drive requests
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
    input  i_ack, i_rdata, d_ack, d_rdata
  );

  // Arbiter answers with acks and read data
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
    output i_ack, i_rdata, d_ack, d_rdata
  );

endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin sequencer for one async SRAM bank
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                clk_50M,
  input  logic                reset_n,
  sram_arbiter_if.slave       bus,
  inout  wire  [DATA_W-1:0]   sram_data,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_be_n,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  localparam int CNT_W = cnt_width(READ_CYCLES, WRITE_CYCLES);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_CYCLES - 1);

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_en;

  // The bus is only driven from a register, so it can never glitch onto the pins
  // while oe_n is low (drive_en and oe_n low are mutually exclusive by state).
  assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  // Single FSM: arbitration, strobe sequencing, data capture and ack generation.
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= INST;
      last_grant <= INST;
      cnt        <= '0;
      drive_en   <= 1'b0;
      sram_addr  <= '0;
      sram_be_n  <= '1;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Data wins when alone, or on a tie when instruction was served last.
          if (bus.d_req && (!bus.i_req || last_grant == INST)) begin
            owner      <= DATA;
            last_grant <= DATA;
            sram_addr  <= bus.d_addr;
            sram_ce_n  <= 1'b0;
            if (bus.d_we) begin
              state     <= WRITE;
              sram_we_n <= 1'b0;
              sram_be_n <= ~bus.d_be;
              wdata_q   <= bus.d_wdata;
              drive_en  <= 1'b1;
            end else begin
              state     <= READ;
              sram_oe_n <= 1'b0;
              sram_be_n <= '0;
            end
          end else if (bus.i_req) begin
            owner      <= INST;
            last_grant <= INST;
            sram_addr  <= bus.i_addr;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_be_n  <= '0;
            state      <= READ;
          end
        end

        READ: begin
          if (cnt == R_LAST) begin
            if (owner == INST) begin
              bus.i_rdata <= sram_data;
              bus.i_ack   <= 1'b1;
            end else begin
              bus.d_rdata <= sram_data;
              bus.d_ack   <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Ack cycle; requests are not sampled here so a held req is seen as new next cycle.
        DONE: begin
          state <= IDLE;
        end

        WRITE: begin
          if (cnt == W_LAST) begin
            sram_we_n <= 1'b1;
            bus.d_ack <= 1'b1;
            state     <= WHOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Data and ce_n held one cycle past the rising we_n edge for hold time.
        WHOLD: begin
          sram_ce_n <= 1'b1;
          sram_be_n <= '1;
          drive_en  <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_be_n <= '1;
          drive_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter
module tb_sram_arbiter;

  logic        clk_50M = 1'b0;
  logic        reset_n = 1'b0;
  wire  [31:0] sram_data;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        probe_en = 1'b0;

  int checks = 0;
  int failures = 0;

  sram_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus ();

  sram_arbiter #(.ADDR_W(20), .DATA_W(32), .READ_CYCLES(2), .WRITE_CYCLES(2)) dut (
    .clk_50M   (clk_50M),
    .reset_n   (reset_n),
    .bus       (bus),
    .sram_data (sram_data),
    .sram_addr (sram_addr),
    .sram_be_n (sram_be_n),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #10 clk_50M = ~clk_50M;

  // SRAM model: small memory, async read while ce/oe low, byte-masked write while ce/we low
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] :
                     (probe_en ? 32'h0 : {32{1'bz}});

  always @(posedge clk_50M) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= {4{i[7:0]}};
      mem[16]   <= 32'h3C08_8000;
      mem[5]    <= 32'h1122_3344;
      mem_ready <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_data[8*b +: 8];
    end
  end

  // Bus monitors
  int i_ack_cnt = 0;
  int d_ack_cnt = 0;
  int we_run = 0;
  int last_we_len = 0;
  bit both_ack = 1'b0;
  bit strobe_overlap = 1'b0;

  always @(negedge clk_50M) begin
    if (bus.i_ack && bus.d_ack) both_ack = 1'b1;
    if (!sram_oe_n && !sram_we_n) strobe_overlap = 1'b1;
    if (bus.i_ack) i_ack_cnt++;
    if (bus.d_ack) d_ack_cnt++;
    if (!sram_we_n) we_run++;
    else if (we_run != 0) begin
      last_we_len = we_run;
      we_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " strobes"}, {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check({tag, " be_n"}, {28'd0, sram_be_n}, 32'hF);
    check({tag, " acks"}, {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
  endtask

  // Pull the bus to 0 from the bench side; any DUT drive would corrupt the value.
  task automatic check_bus_released(input string tag);
    probe_en = 1'b1;
    #3;
    check({tag, " bus released"}, sram_data, 32'h0);
    probe_en = 1'b0;
  endtask

  task automatic access(input bit inst, input bit we, input logic [19:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output bit single);
    @(posedge clk_50M); #1;
    if (inst) begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end else begin
      bus.d_addr = addr; bus.d_we = we; bus.d_be = be; bus.d_wdata = wd; bus.d_req = 1'b1;
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_50M); #1;
      if ((inst && bus.i_ack) || (!inst && bus.d_ack)) begin
        lat = k;
        break;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    rd = inst ? bus.i_rdata : bus.d_rdata;
    @(posedge clk_50M); #1;
    single = inst ? !bus.i_ack : !bus.d_ack;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk_50M);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          inst;
    bit          we;
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat;
    logic [31:0] rd;
    bit          single;
    int          d0;
    int          i0;
    string       order;

    vecs[0] = '{1'b1, 1'b0, 20'h00010, 4'h0, 32'h0,          32'h3C08_8000};
    vecs[1] = '{1'b0, 1'b1, 20'h00005, 4'h2, 32'hAABB_CCDD,  32'h0};
    vecs[2] = '{1'b0, 1'b0, 20'h00005, 4'h0, 32'h0,          32'h1122_CC44};
    vecs[3] = '{1'b0, 1'b1, 20'h00007, 4'hF, 32'hDEAD_BEEF,  32'h0};
    vecs[4] = '{1'b1, 1'b0, 20'h00007, 4'h0, 32'h0,          32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b1, 20'h00007, 4'h0, 32'h5555_5555,  32'h0};
    vecs[6] = '{1'b0, 1'b0, 20'h00007, 4'h0, 32'h0,          32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 1'b1, 20'h00008, 4'h9, 32'hA1B2_C3D4,  32'h0};
    vecs[8] = '{1'b1, 1'b0, 20'h00008, 4'h0, 32'h0,          32'hA108_08D4};

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_be = '0; bus.d_wdata = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    check_idle_outputs("reset");
    check("reset sram_addr", {12'd0, sram_addr}, 32'h0);
    check("reset i_rdata", bus.i_rdata, 32'h0);
    check("reset d_rdata", bus.d_rdata, 32'h0);
    reset_n = 1'b1;

    // Single-requester vectors: ack latency, single pulse, data, write strobe width
    for (int v = 0; v < 9; v++) begin
      access(vecs[v].inst, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wd, lat, rd, single);
      check($sformatf("vec%0d ack latency", v), lat, 32'd3);
      check($sformatf("vec%0d single ack", v), {31'd0, single}, 32'd1);
      if (vecs[v].we) begin
        check($sformatf("vec%0d we_n low cycles", v), last_we_len, 32'd2);
        check_bus_released($sformatf("vec%0d", v));
      end else begin
        check($sformatf("vec%0d rdata", v), rd, vecs[v].exp);
      end
    end

    // Reset for 3 cycles in the middle of an instruction read
    i0 = i_ack_cnt;
    @(posedge clk_50M); #1;
    bus.i_addr = 20'h00010; bus.i_req = 1'b1;
    @(posedge clk_50M); #1;
    check("midread oe_n low", {31'd0, sram_oe_n}, 32'd0);
    reset_n = 1'b0;
    bus.i_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_50M); #1;
      check_idle_outputs($sformatf("midread reset c%0d", c));
    end
    check_bus_released("midread reset");
    check("midread i_rdata cleared", bus.i_rdata, 32'h0);
    check("midread d_rdata cleared", bus.d_rdata, 32'h0);
    reset_n = 1'b1;
    repeat (6) @(posedge clk_50M);
    #1;
    check("midread no i_ack", i_ack_cnt - i0, 32'd0);

    // Simultaneous continuous requests alternate D,I,D,I
    do_reset(2);
    @(posedge clk_50M); #1;
    bus.i_addr = 20'h00010; bus.i_req = 1'b1;
    bus.d_addr = 20'h00005; bus.d_we = 1'b0; bus.d_req = 1'b1;
    order = "";
    for (int k = 0; k < 40 && order.len() < 4; k++) begin
      @(posedge clk_50M); #1;
      if (bus.d_ack) begin
        order = {order, "D"};
        check("rr d_rdata", bus.d_rdata, 32'h1122_CC44);
      end
      if (bus.i_ack) begin
        order = {order, "I"};
        check("rr i_rdata", bus.i_rdata, 32'h3C08_8000);
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    checks++;
    if (order != "DIDI") begin
      failures++;
      $display("FAIL rr grant order: got=%s expected=DIDI", order);
    end
    check("rr acks never together", {31'd0, both_ack}, 32'd0);

    // Reset during the first write cycle drops the transaction
    repeat (3) @(posedge clk_50M);
    #1;
    d0 = d_ack_cnt;
    bus.d_addr = 20'h00009; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_wdata = 32'h1234_5678;
    bus.d_req = 1'b1;
    @(posedge clk_50M); #1;
    check("wreset in WRITE we_n", {31'd0, sram_we_n}, 32'd0);
    reset_n = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk_50M); #1;
    check_idle_outputs("wreset");
    check_bus_released("wreset");
    reset_n = 1'b1;
    repeat (6) @(posedge clk_50M);
    #1;
    check("wreset no d_ack", d_ack_cnt - d0, 32'd0);

    // Held d_req across ack with a new address is a fresh request
    d0 = d_ack_cnt;
    bus.d_addr = 20'h00003; bus.d_we = 1'b0; bus.d_req = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_50M); #1;
      if (bus.d_ack) begin lat = k; break; end
    end
    check("held first latency", lat, 32'd3);
    check("held first rdata", bus.d_rdata, 32'h0303_0303);
    bus.d_addr = 20'h00004;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_50M); #1;
      if (bus.d_ack) begin lat = k; break; end
    end
    bus.d_req = 1'b0;
    check("held second latency", lat, 32'd4);
    check("held second rdata", bus.d_rdata, 32'h0404_0404);
    repeat (8) @(posedge clk_50M);
    #1;
    check("held ack count", d_ack_cnt - d0, 32'd2);

    check("oe_n and we_n never low together", {31'd0, strobe_overlap}, 32'd0);
    check("acks never together", {31'd0, both_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
